// File: rtl/yin_pkg.sv
// Shared constants and FSM state encoding for the YIN lag sweeper.
package yin_pkg;

  // Width of the difference value d(tau) returned by the engine
  localparam int INTERMEDIATE_DATA_WIDTH = 64;
  // Last lag swept (20 ms)
  localparam int MAX_TAU   = 40;
  // Width of every lag-valued signal
  localparam int TAU_WIDTH = 6;
  // First lag eligible for threshold detection
  localparam int TAU_MIN   = 2;
  // CMNDF threshold in Q0.8 (38/256 ~= 0.15)
  localparam int THRESH    = 38;
  // Maximum cycles spent waiting on the engine for one lag
  localparam int TIMEOUT   = 512;
  // Fractional bits of the threshold format
  localparam int Q_BITS    = 8;
  // Running sum of up to 64 lags of 64-bit d never overflows 70 bits
  localparam int SUM_WIDTH = 70;
  // Width of the cross-multiplied threshold comparison
  localparam int CMP_WIDTH = 80;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WAIT = 3'd2,
    ST_EVAL = 3'd3,
    ST_DONE = 3'd4
  } sweep_state_e;

endpackage

// File: rtl/yin_cmndf_cmp.sv
// Division-free CMNDF threshold test: d*tau*2^Q < THRESH*S, unsigned at 80 bits.
module yin_cmndf_cmp
  import yin_pkg::*;
#(
  parameter int D_WIDTH   = INTERMEDIATE_DATA_WIDTH,
  parameter int S_WIDTH   = SUM_WIDTH,
  parameter int LAG_MIN   = TAU_MIN,
  parameter int THRESH_Q8 = THRESH
) (
  input  logic [D_WIDTH-1:0]   d,
  input  logic [TAU_WIDTH-1:0] tau,
  input  logic [S_WIDTH-1:0]   s,
  output logic                 hit
);

  logic [CMP_WIDTH-1:0] w_lhs;
  logic [CMP_WIDTH-1:0] w_rhs;

  // d(tau) / ((1/tau) * S) < THRESH/256 rearranged so that no divider is needed
  assign w_lhs = (CMP_WIDTH'(d) * CMP_WIDTH'(tau)) << Q_BITS;
  assign w_rhs = CMP_WIDTH'(THRESH_Q8) * CMP_WIDTH'(s);

  // A zero running sum means silence: the normalised value is undefined, never a hit
  assign hit = (tau >= TAU_WIDTH'(LAG_MIN)) && (s != '0) && (w_lhs < w_rhs);

endmodule

// File: rtl/yin_tau_sweeper.sv
// Sweeps lags 1..MAX_TAU through an external difference engine and reports the
// first lag whose cumulative-mean-normalised difference falls below threshold.
module yin_tau_sweeper #(
  parameter int INTERMEDIATE_DATA_WIDTH = yin_pkg::INTERMEDIATE_DATA_WIDTH,
  parameter int MAX_TAU                 = yin_pkg::MAX_TAU,
  parameter int TAU_MIN                 = yin_pkg::TAU_MIN,
  parameter int THRESH                  = yin_pkg::THRESH,
  parameter int TIMEOUT                 = yin_pkg::TIMEOUT
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  output logic [yin_pkg::TAU_WIDTH-1:0]       diff_tau,
  output logic                                diff_reset,
  input  logic                                diff_ready,
  input  logic [INTERMEDIATE_DATA_WIDTH-1:0]  diff_value,
  output logic                                busy,
  output logic                                done,
  output logic [yin_pkg::TAU_WIDTH-1:0]       period,
  output logic                                period_valid,
  output logic                                error
);

  import yin_pkg::*;

  localparam int DW   = INTERMEDIATE_DATA_WIDTH;
  localparam int TW   = TAU_WIDTH;
  localparam int SW   = SUM_WIDTH;
  localparam int TO_W = $clog2(TIMEOUT + 1);

  sweep_state_e    r_state;
  sweep_state_e    w_state_next;
  logic [TW-1:0]   r_tau;
  logic [TW-1:0]   w_tau_next;
  logic [SW-1:0]   r_sum;
  logic [SW-1:0]   w_sum_next;
  logic [SW-1:0]   w_sum_new;
  logic [DW-1:0]   r_d;
  logic [DW-1:0]   w_d_next;
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_cnt_next;
  logic [TO_W-1:0] w_to_cnt_inc;
  logic [TW-1:0]   r_diff_tau;
  logic [TW-1:0]   w_diff_tau_next;
  logic            r_diff_reset;
  logic            w_diff_reset_next;
  logic            r_busy;
  logic            w_busy_next;
  logic            r_done;
  logic            w_done_next;
  logic [TW-1:0]   r_period;
  logic [TW-1:0]   w_period_next;
  logic            r_period_valid;
  logic            w_period_valid_next;
  logic            r_error;
  logic            w_error_next;
  logic            w_hit;

  // S after adding the d latched for the current lag
  assign w_sum_new    = r_sum + SW'(r_d);
  assign w_to_cnt_inc = r_to_cnt + TO_W'(1);

  yin_cmndf_cmp #(
    .D_WIDTH   (DW),
    .S_WIDTH   (SW),
    .LAG_MIN   (TAU_MIN),
    .THRESH_Q8 (THRESH)
  ) u_cmp (
    .d   (r_d),
    .tau (r_tau),
    .s   (w_sum_new),
    .hit (w_hit)
  );

  // Sweep FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus next values of every datapath and output register
  always_comb begin
    w_state_next        = r_state;
    w_tau_next          = r_tau;
    w_sum_next          = r_sum;
    w_d_next            = r_d;
    w_to_cnt_next       = r_to_cnt;
    w_diff_tau_next     = r_diff_tau;
    w_busy_next         = r_busy;
    w_done_next         = 1'b0;
    w_period_next       = r_period;
    w_period_valid_next = r_period_valid;
    w_error_next        = r_error;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_tau_next          = TW'(1);
          w_sum_next          = '0;
          w_period_next       = '0;
          w_period_valid_next = 1'b0;
          w_error_next        = 1'b0;
          w_busy_next         = 1'b1;
          // Lag is presented to the engine already during LOAD
          w_diff_tau_next     = TW'(1);
          w_state_next        = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_to_cnt_next = '0;
        w_state_next  = ST_WAIT;
      end
      ST_WAIT: begin
        if (diff_ready) begin
          w_d_next     = diff_value;
          w_state_next = ST_EVAL;
        end else if (w_to_cnt_inc == TO_W'(TIMEOUT)) begin
          w_to_cnt_next       = w_to_cnt_inc;
          w_error_next        = 1'b1;
          w_period_next       = '0;
          w_period_valid_next = 1'b0;
          w_busy_next         = 1'b0;
          w_done_next         = 1'b1;
          w_state_next        = ST_DONE;
        end else begin
          w_to_cnt_next = w_to_cnt_inc;
        end
      end
      ST_EVAL: begin
        w_sum_next = w_sum_new;
        if (w_hit) begin
          w_period_next       = r_tau;
          w_period_valid_next = 1'b1;
          w_busy_next         = 1'b0;
          w_done_next         = 1'b1;
          w_state_next        = ST_DONE;
        end else if (r_tau == TW'(MAX_TAU)) begin
          w_period_next       = '0;
          w_period_valid_next = 1'b0;
          w_busy_next         = 1'b0;
          w_done_next         = 1'b1;
          w_state_next        = ST_DONE;
        end else begin
          w_tau_next      = r_tau + TW'(1);
          w_diff_tau_next = r_tau + TW'(1);
          w_state_next    = ST_LOAD;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    // Engine is held in reset everywhere except while its sum is being built
    w_diff_reset_next = (w_state_next != ST_WAIT);
  end

  // Datapath and registered outputs; reset aborts any sweep without a done pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tau          <= '0;
      r_sum          <= '0;
      r_d            <= '0;
      r_to_cnt       <= '0;
      r_diff_tau     <= '0;
      r_diff_reset   <= 1'b1;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_tau          <= w_tau_next;
      r_sum          <= w_sum_next;
      r_d            <= w_d_next;
      r_to_cnt       <= w_to_cnt_next;
      r_diff_tau     <= w_diff_tau_next;
      r_diff_reset   <= w_diff_reset_next;
      r_busy         <= w_busy_next;
      r_done         <= w_done_next;
      r_period       <= w_period_next;
      r_period_valid <= w_period_valid_next;
      r_error        <= w_error_next;
    end
  end

  assign diff_tau     = r_diff_tau;
  assign diff_reset   = r_diff_reset;
  assign busy         = r_busy;
  assign done         = r_done;
  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign error        = r_error;

endmodule

// File: tb/tb_yin_tau_sweeper.sv
// Scoreboard bench for yin_tau_sweeper with a behavioural difference engine.
module tb_yin_tau_sweeper;

  localparam int DW          = 64;
  localparam int READY_DELAY = 256;
  // LOAD + (READY_DELAY+1) WAIT cycles + EVAL for each lag with this engine model
  localparam int LAG_CYC     = READY_DELAY + 3;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [5:0]    diff_tau;
  logic          diff_reset;
  logic          diff_ready;
  logic [DW-1:0] diff_value;
  logic          busy;
  logic          done;
  logic [5:0]    period;
  logic          period_valid;
  logic          error;

  yin_tau_sweeper dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .diff_tau     (diff_tau),
    .diff_reset   (diff_reset),
    .diff_ready   (diff_ready),
    .diff_value   (diff_value),
    .busy         (busy),
    .done         (done),
    .period       (period),
    .period_valid (period_valid),
    .error        (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural difference engine: ready READY_DELAY cycles after release from reset
  logic [DW-1:0] d_table [0:63];
  logic          m_hang;
  int            m_cnt = 0;

  always @(posedge clk) begin
    if (diff_reset) m_cnt <= 0;
    else if (m_cnt < 100000) m_cnt <= m_cnt + 1;
  end

  assign diff_ready = !m_hang && (m_cnt >= READY_DELAY);
  assign diff_value = diff_ready ? d_table[diff_tau] : '0;

  // Scoreboard
  typedef struct {
    int period;
    int pv;
    int err;
    int lags;
    int last_tau;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   total    = 0;
  int   bad      = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic push(input int p, input int pv, input int err, input int lags,
                      input int last_tau, input int lat);
    exp_t e;
    e.period   = p;
    e.pv       = pv;
    e.err      = err;
    e.lags     = lags;
    e.last_tau = last_tau;
    e.lat      = lat;
    exp_q.push_back(e);
  endtask

  // Monitor: tracks lags presented to the engine and checks each done pulse
  initial begin : monitor
    int         cyc;
    int         lags;
    int         first_tau;
    int         last_tau;
    int         t_first;
    int         stab;
    int         sweep_no;
    logic       prev_dr;
    logic [5:0] prev_tau;
    exp_t       e;
    cyc = 0; lags = 0; first_tau = 0; last_tau = 0; t_first = 0; stab = 0; sweep_no = 0;
    prev_dr = 1'b1;
    prev_tau = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        lags = 0;
        stab = 0;
      end else begin
        if (prev_dr && !diff_reset) begin
          lags++;
          if (lags == 1) begin
            first_tau = int'(diff_tau);
            t_first   = cyc;
          end
          last_tau = int'(diff_tau);
        end
        if (!prev_dr && !diff_reset && diff_tau != prev_tau) stab++;
        if (done) begin
          done_cnt++;
          sweep_no++;
          $display("sweep %0d: period=%0d period_valid=%0d error=%0d lags=%0d last_tau=%0d latency=%0d",
                   sweep_no, period, period_valid, error, lags, last_tau, cyc - t_first);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got a done pulse, want none");
          end else begin
            e = exp_q.pop_front();
            chk("period", period, e.period);
            chk("period_valid", period_valid, e.pv);
            chk("error", error, e.err);
            chk("busy_at_done", busy, 0);
            chk("lag_count", lags, e.lags);
            chk("first_tau", first_tau, 1);
            chk("last_tau", last_tau, e.last_tau);
            chk("latency", cyc - t_first, e.lat);
            chk("tau_stable_in_wait", stab, 0);
          end
          lags = 0;
          stab = 0;
        end
      end
      prev_dr  = diff_reset;
      prev_tau = diff_tau;
    end
  end

  task automatic set_all(input logic [DW-1:0] v);
    for (int i = 0; i < 64; i++) d_table[i] = v;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c0;
    int n;
    c0 = done_cnt;
    n  = 0;
    while (done_cnt == c0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("sweep_finished", (done_cnt != c0) ? 1 : 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_tau(input int t, input int budget);
    int n;
    n = 0;
    while (!(diff_tau == 6'(t) && !diff_reset) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wait_tau", (diff_tau == 6'(t) && !diff_reset) ? 1 : 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_diff_reset"}, diff_reset, 1);
    chk({tag, "_diff_tau"}, diff_tau, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_period_valid"}, period_valid, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int d0;
    start   = 1'b0;
    reset_n = 1'b0;
    m_hang  = 1'b0;
    set_all(64'd1000);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Voiced: d(1..3)=1000, d(4)=10 -> hit at tau=4
    set_all(64'd1000);
    d_table[4] = 64'd10;
    push(4, 1, 0, 4, 4, 4 * LAG_CYC - 1);
    pulse_start();
    wait_done(2000);
    repeat (5) @(negedge clk);
    chk("period_valid_held", period_valid, 1);
    chk("period_held", period, 4);
    chk("busy_idle", busy, 0);

    // Flat d: never below threshold, full sweep to MAX_TAU
    set_all(64'd1000);
    push(0, 0, 0, 40, 40, 40 * LAG_CYC - 1);
    pulse_start();
    wait_done(12000);

    // Silence: S stays 0, no hit, no error
    set_all(64'd0);
    push(0, 0, 0, 40, 40, 40 * LAG_CYC - 1);
    pulse_start();
    wait_done(12000);

    // Engine never ready: timeout on the first lag
    m_hang = 1'b1;
    push(0, 0, 1, 1, 1, 512);
    pulse_start();
    wait_done(1000);
    repeat (5) @(negedge clk);
    chk("error_held", error, 1);
    m_hang = 1'b0;

    // Reset pulsed mid-WAIT at tau=7, then a fresh sweep
    set_all(64'd1000);
    push(0, 0, 0, 40, 40, 40 * LAG_CYC - 1);
    pulse_start();
    chk("error_cleared_by_start", error, 0);
    chk("busy_after_start", busy, 1);
    wait_tau(7, 3000);
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("abort");
    exp_q.delete();
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_done_on_abort", done_cnt, d0);
    d_table[4] = 64'd10;
    push(4, 1, 0, 4, 4, 4 * LAG_CYC - 1);
    pulse_start();
    wait_done(2000);

    // Start pulsed while busy is ignored
    set_all(64'd1000);
    d_table[4] = 64'd10;
    push(4, 1, 0, 4, 4, 4 * LAG_CYC - 1);
    pulse_start();
    wait_tau(2, 1000);
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
